// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide unit; MULDIV_FAST_MUL_EN selects single-cycle multiplies
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_r,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state_q, state_d;
    logic [2:0] op_q, op_d;
    logic neg_q, neg_d, rneg_q, rneg_d;
    logic [XLEN-1:0] b_q, b_d, r_q, r_d;
    logic [2*XLEN-1:0] p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic a_sgn, b_sgn, sa, sb;
    logic [XLEN-1:0] a_mag, b_mag, quo, rem, res;
    logic [XLEN:0] sum, diff;
    logic [2*XLEN-1:0] p_mul, p_div, prod;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fprod;
    assign fprod = {{XLEN{sa}}, req_a} * {{XLEN{sb}}, req_b};
`endif
    assign a_sgn = (req_op == 3'b001) | (req_op == 3'b010) | (req_op == 3'b100) | (req_op == 3'b110);
    assign b_sgn = (req_op == 3'b001) | (req_op == 3'b100) | (req_op == 3'b110);
    assign sa = a_sgn & req_a[XLEN-1];
    assign sb = b_sgn & req_b[XLEN-1];
    assign a_mag = sa ? -req_a : req_a;
    assign b_mag = sb ? -req_b : req_b;
    assign req_ready = state_q == IDLE;
    assign resp_valid = state_q == DONE;
    assign busy = state_q != IDLE;
    assign resp_r = r_q;
    always_comb begin
        sum = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, b_q} : '0);
        p_mul = {sum, p_q[XLEN-1:1]};
        // shift-subtract: low half collects quotient bits, high half holds the partial remainder
        diff = p_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
        p_div = diff[XLEN] ? {p_q[2*XLEN-2:0], 1'b0} : {diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
        prod = neg_q ? -p_mul : p_mul;
        quo = neg_q ? -p_div[XLEN-1:0] : p_div[XLEN-1:0];
        rem = rneg_q ? -p_div[2*XLEN-1:XLEN] : p_div[2*XLEN-1:XLEN];
        res = op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
        state_d = state_q;
        op_d = op_q;
        neg_d = neg_q;
        rneg_d = rneg_q;
        b_d = b_q;
        p_d = p_q;
        r_d = r_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (req_valid) begin
                op_d = req_op;
                neg_d = sa ^ sb;
                rneg_d = sa;
                b_d = b_mag;
                p_d = {{XLEN{1'b0}}, a_mag};
                cnt_d = '0;
                state_d = CALC;
                if (req_op[2] && req_b == '0) begin
                    r_d = req_op[1] ? req_a : '1;
                    state_d = DONE;
                end else if (req_op[2] && !req_op[0] && req_a == {1'b1, {(XLEN-1){1'b0}}} && req_b == '1) begin
                    r_d = req_op[1] ? '0 : req_a;
                    state_d = DONE;
                end
`ifdef MULDIV_FAST_MUL_EN
                else if (!req_op[2]) begin
                    r_d = req_op[1:0] == 2'b00 ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
                    state_d = DONE;
                end
`endif
            end
            CALC: begin
                p_d = op_q[2] ? p_div : p_mul;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    r_d = res;
                    state_d = DONE;
                end
            end
            DONE: state_d = resp_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q <= '0;
            neg_q <= 1'b0;
            rneg_q <= 1'b0;
            b_q <= '0;
            p_q <= '0;
            r_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            neg_q <= neg_d;
            rneg_q <= rneg_d;
            b_q <= b_d;
            p_q <= p_d;
            r_q <= r_d;
            cnt_q <= cnt_d;
        end
    end
endmodule
